// File: rtl/down_seq_pkg.sv
// Shared state encoding and default geometry for the downsampled frame sequencer.
package down_seq_pkg;

    localparam int unsigned LINE_WIDTH_DFLT  = 160;
    localparam int unsigned FRAME_LINES_DFLT = 120;
    localparam int unsigned VBLANK_MIN_DFLT  = 32;
    localparam int unsigned RUN_W            = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HBLANK,
        ST_LINE
    } seq_state_e;

endpackage

// File: rtl/blank_run_detector.sv
// Counts consecutive valid blanking samples; vblank_o fires on the sample that
// completes a run of VBLANK_MIN.
module blank_run_detector
    import down_seq_pkg::*;
#(
    parameter int unsigned VBLANK_MIN = VBLANK_MIN_DFLT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic valid_i,
    input  logic blank_i,
    output logic vblank_o
);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(VBLANK_MIN - 1);

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    // Held at zero while disabled so every SYNC entry starts a fresh run.
    always_comb begin
        vblank_o = enable_i && valid_i && blank_i && (run_q == RUN_LAST);
        run_d    = run_q;
        if (!enable_i || vblank_o) begin
            run_d = '0;
        end else if (valid_i) begin
            run_d = blank_i ? run_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/down_frame_sequencer.sv
// Frames a downsampled sample stream into lines/frames of active pixels with
// x/y coordinates and sof/eol/eof markers.
module down_frame_sequencer
    import down_seq_pkg::*;
#(
    parameter int unsigned LINE_WIDTH  = LINE_WIDTH_DFLT,
    parameter int unsigned FRAME_LINES = FRAME_LINES_DFLT,
    parameter int unsigned VBLANK_MIN  = VBLANK_MIN_DFLT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [7:0]  data,
    input  logic        blankingregion,
    input  logic        start,
    input  logic        continuous,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic        sof,
    output logic        eol,
    output logic        eof,
    output logic        busy,
    output logic        line_err,
    output logic [15:0] frame_cnt
);

    localparam logic [7:0] X_LAST = 8'(LINE_WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(FRAME_LINES - 1);

    seq_state_e  state_q;
    logic [7:0]  col_q;
    logic [6:0]  row_q;
    logic [7:0]  pix_data_q;
    logic        pix_valid_q;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic        sof_q;
    logic        eol_q;
    logic        eof_q;
    logic        line_err_q;
    logic [15:0] frame_cnt_q;

    logic vblank;
    logic pix_fire;
    logic line_done;
    logic frame_done;

    blank_run_detector #(
        .VBLANK_MIN(VBLANK_MIN)
    ) u_blank_run (
        .clk_i   (clock),
        .rst_i   (reset),
        .enable_i(state_q == ST_SYNC),
        .valid_i (valid),
        .blank_i (blankingregion),
        .vblank_o(vblank)
    );

    // HBLANK and LINE share the emit path: the first pixel of a line leaves HBLANK.
    assign pix_fire   = valid && !blankingregion && (state_q == ST_HBLANK || state_q == ST_LINE);
    assign line_done  = (col_q == X_LAST);
    assign frame_done = line_done && (row_q == Y_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            line_err_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            pix_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            line_err_q  <= 1'b0;
            if (pix_fire) begin
                pix_data_q  <= data;
                pix_valid_q <= 1'b1;
                x_q         <= col_q;
                y_q         <= row_q;
                sof_q       <= (col_q == '0) && (row_q == '0);
                eol_q       <= line_done;
                eof_q       <= frame_done;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (vblank) begin
                        state_q <= ST_HBLANK;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                ST_HBLANK, ST_LINE: begin
                    if (pix_fire) begin
                        if (line_done) begin
                            col_q   <= '0;
                            row_q   <= row_q + 1'b1;
                            state_q <= ST_HBLANK;
                            if (frame_done) begin
                                frame_cnt_q <= frame_cnt_q + 1'b1;
                                state_q     <= continuous ? ST_SYNC : ST_IDLE;
                            end
                        end else begin
                            col_q   <= col_q + 1'b1;
                            state_q <= ST_LINE;
                        end
                    end else if (valid && state_q == ST_LINE) begin
                        line_err_q <= 1'b1;
                        state_q    <= ST_SYNC;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign x         = x_q;
    assign y         = y_q;
    assign sof       = sof_q;
    assign eol       = eol_q;
    assign eof       = eof_q;
    assign line_err  = line_err_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_down_frame_sequencer.sv
// Bench for down_frame_sequencer: a pixel-index reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_down_frame_sequencer;

    localparam int LW  = 40;
    localparam int FL  = 12;
    localparam int VB  = 32;
    localparam int GAP = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  data = '0;
    logic        blankingregion = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic [7:0]  x;
    logic [6:0]  y;
    logic        sof;
    logic        eol;
    logic        eof;
    logic        busy;
    logic        line_err;
    logic [15:0] frame_cnt;

    down_frame_sequencer #(
        .LINE_WIDTH (LW),
        .FRAME_LINES(FL),
        .VBLANK_MIN (VB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .valid         (valid),
        .data          (data),
        .blankingregion(blankingregion),
        .start         (start),
        .continuous    (continuous),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .x             (x),
        .y             (y),
        .sof           (sof),
        .eol           (eol),
        .eof           (eof),
        .busy          (busy),
        .line_err      (line_err),
        .frame_cnt     (frame_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0 = disarmed, 1 = hunting for vblank, 2 = in frame.
    // Frame position is a linear pixel index; x/y and line boundaries derive from it.
    int          m_mode = 0;
    int          m_run = 0;
    int          m_p = 0;
    logic        e_pv = 0, e_sof = 0, e_eol = 0, e_eof = 0, e_err = 0, e_busy = 0;
    logic [7:0]  e_data = '0;
    int          e_x = 0, e_y = 0;
    logic [15:0] e_fc = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_run = 0; m_p = 0;
            e_pv = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_err = 0; e_busy = 0;
            e_data = '0; e_x = 0; e_y = 0; e_fc = '0;
        end else begin
            e_pv = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_err = 0;
            if (m_mode == 0) begin
                if (start) begin m_mode = 1; m_run = 0; end
            end else if (valid) begin
                if (m_mode == 1) begin
                    if (blankingregion) begin
                        m_run++;
                        if (m_run == VB) begin m_mode = 2; m_p = 0; end
                    end else begin
                        m_run = 0;
                    end
                end else if (!blankingregion) begin
                    e_pv = 1; e_data = data;
                    e_x = m_p % LW; e_y = m_p / LW;
                    e_sof = (m_p == 0);
                    e_eol = (m_p % LW == LW - 1);
                    m_p++;
                    if (m_p == LW * FL) begin
                        e_eof = 1; e_fc = e_fc + 16'd1;
                        m_mode = continuous ? 1 : 0; m_run = 0;
                    end
                end else if (m_p % LW != 0) begin
                    e_err = 1; m_mode = 1; m_run = 0;
                end
            end
            e_busy = (m_mode != 0);
        end
    end

    // Literal-expectation mailbox, consumed by the compare process.
    int          checks = 0;
    int          errors = 0;
    int          lit_seq = 0, lit_done = 0;
    string       lit_name = "";
    int          lit_act = 0, lit_exp = 0;
    bit          finish_req = 0;
    int          n_pix = 0, n_sof = 0, n_eol = 0, n_eof = 0, n_err = 0, n_idle = 0;
    int          sof_x = -1, sof_y = -1, eof_x = -1, eof_y = -1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            check(lit_name, lit_act, lit_exp);
        end
        check("pix_valid", int'(pix_valid), int'(e_pv));
        check("pix_data",  int'(pix_data),  int'(e_data));
        check("x",         int'(x),         e_x);
        check("y",         int'(y),         e_y);
        check("sof",       int'(sof),       int'(e_sof));
        check("eol",       int'(eol),       int'(e_eol));
        check("eof",       int'(eof),       int'(e_eof));
        check("line_err",  int'(line_err),  int'(e_err));
        check("busy",      int'(busy),      int'(e_busy));
        check("frame_cnt", int'(frame_cnt), int'(e_fc));
        if (pix_valid === 1'b1) n_pix++;
        if (sof === 1'b1) begin n_sof++; sof_x = int'(x); sof_y = int'(y); end
        if (eol === 1'b1) n_eol++;
        if (eof === 1'b1) begin n_eof++; eof_x = int'(x); eof_y = int'(y); end
        if (line_err === 1'b1) n_err++;
        if (busy !== 1'b1) n_idle++;
        if (finish_req) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    int gap_mode = 0;

    task automatic pin(input string nm, input int act, input int exp);
        valid = 1'b0; start = 1'b0;
        lit_name = nm; lit_act = act; lit_exp = exp;
        lit_seq++;
        @(negedge clock); #1;
    endtask

    task automatic smp(input bit v, input bit b);
        valid = v; blankingregion = b; data = 8'($urandom); start = 1'b0;
        @(negedge clock); #1;
    endtask

    task automatic put(input bit b);
        if (gap_mode == 1) smp(1'b0, 1'($urandom));
        if (gap_mode == 2) while ($urandom_range(0, 3) == 0) smp(1'b0, 1'($urandom));
        smp(1'b1, b);
    endtask

    task automatic blanks(input int n);
        for (int i = 0; i < n; i++) put(1'b1);
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) put(1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) smp(1'b0, 1'b0);
    endtask

    task automatic arm(input bit c);
        continuous = c; start = 1'b1; valid = 1'b0;
        @(negedge clock); #1;
        start = 1'b0;
    endtask

    task automatic lines(input int n);
        for (int l = 0; l < n; l++) begin pixels(LW); blanks(GAP); end
    endtask

    task automatic frame();
        blanks(40); lines(FL);
    endtask

    task automatic hit_reset();
        reset = 1'b1;
        idle(3);
    endtask

    int b_pix, b_sof, b_eol, b_eof, b_err, b_idle;

    task automatic snap();
        b_pix = n_pix; b_sof = n_sof; b_eol = n_eol;
        b_eof = n_eof; b_err = n_err; b_idle = n_idle;
    endtask

    task automatic pin_frame(input string tag, input int fc);
        pin({tag, "_pix"}, n_pix - b_pix, LW * FL);
        pin({tag, "_sof"}, n_sof - b_sof, 1);
        pin({tag, "_eol"}, n_eol - b_eol, FL);
        pin({tag, "_eof"}, n_eof - b_eof, 1);
        pin({tag, "_err"}, n_err - b_err, 0);
        pin({tag, "_sof_xy"}, sof_x * 1000 + sof_y, 0);
        pin({tag, "_eof_xy"}, eof_x * 1000 + eof_y, (LW - 1) * 1000 + (FL - 1));
        pin({tag, "_frame_cnt"}, int'(frame_cnt), fc);
        pin({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clock); #1;
        idle(2);
        pin("rst_pix_valid", int'(pix_valid), 0);
        pin("rst_busy", int'(busy), 0);
        pin("rst_frame_cnt", int'(frame_cnt), 0);
        reset = 1'b0;
        idle(2);

        // Nominal single frame.
        snap(); arm(1'b0); frame(); idle(4);
        pin_frame("nominal", 1);

        // Same frame with valid low every other cycle.
        gap_mode = 1;
        snap(); arm(1'b0); frame(); idle(4);
        pin_frame("gaps", 2);
        gap_mode = 0;

        // Continuous: three frames back to back, never leaving busy.
        arm(1'b1); snap();
        frame(); frame(); frame(); idle(4);
        pin("cont_frame_cnt", int'(frame_cnt), 5);
        pin("cont_sof", n_sof - b_sof, 3);
        pin("cont_eof", n_eof - b_eof, 3);
        pin("cont_idle_cycles", n_idle - b_idle, 0);
        pin("cont_busy", int'(busy), 1);
        hit_reset();
        pin("cont_rst_frame_cnt", int'(frame_cnt), 0);
        reset = 1'b0; idle(2);

        // Short line 5, then recovery into a full frame.
        snap(); arm(1'b0); blanks(40); lines(5); pixels(LW / 2); blanks(1); idle(2);
        pin("short_err", n_err - b_err, 1);
        pin("short_eol", n_eol - b_eol, 5);
        pin("short_busy", int'(busy), 1);
        frame(); idle(4);
        pin("short_sof", n_sof - b_sof, 2);
        pin("short_sof_xy", sof_x * 1000 + sof_y, 0);
        pin("short_frame_cnt", int'(frame_cnt), 1);

        // Reset mid-frame at line 6.
        arm(1'b0); blanks(40); lines(FL / 2); pixels(LW / 2);
        snap();
        hit_reset();
        pin("mid_pix_valid", int'(pix_valid), 0);
        pin("mid_pix_data", int'(pix_data), 0);
        pin("mid_xy", int'(x) + int'(y), 0);
        pin("mid_busy", int'(busy), 0);
        pin("mid_frame_cnt", int'(frame_cnt), 0);
        pin("mid_eof_err", (n_eof - b_eof) + (n_err - b_err), 0);
        reset = 1'b0; idle(2);
        snap(); arm(1'b0); frame(); idle(4);
        pin_frame("after_rst", 1);

        // Sync debounce: a single non-blanking sample restarts the run.
        snap(); arm(1'b0); blanks(VB - 1); pixels(1); blanks(VB - 1); idle(2);
        pin("deb_pix", n_pix - b_pix, 0);
        blanks(1); pixels(1); idle(2);
        pin("deb_pix_after", n_pix - b_pix, 1);
        pin("deb_sof", n_sof - b_sof, 1);
        hit_reset(); reset = 1'b0; idle(2);

        // Randomised line/blank segments with random gaps, starts and mode changes.
        gap_mode = 2;
        arm(1'b1);
        for (int seg = 0; seg < 220; seg++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 6) arm(1'($urandom));
            else if (r < 16) blanks(int'($urandom_range(VB - 2, VB + 12)));
            else if (r < 26) begin pixels(int'($urandom_range(1, LW + 4))); blanks(int'($urandom_range(1, 6))); end
            else begin pixels(LW); blanks(int'($urandom_range(1, GAP))); end
            if ($urandom_range(0, 19) == 0) continuous = 1'($urandom);
        end
        idle(4);
        finish_req = 1'b1;
        repeat (4) @(negedge clock);
        $display("FAIL summary_not_reached: got 0 expected 1");
        $fatal(1);
    end

endmodule

// File: doc/down_frame_sequencer.md
DOWN_FRAME_SEQUENCER -- requirements
Module: down_frame_sequencer

Interface
REQ-001 Parameter LINE_WIDTH, default 160, active downsampled samples per line (max 255).
REQ-002 Parameter FRAME_LINES, default 120, active lines per frame (max 127).
REQ-003 Parameter VBLANK_MIN, default 32, consecutive blanking samples that mark vertical blank (max 1023).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; its ports SHALL be exactly:
- clock  in  1  sole clock
- reset  in  1  async active-high reset
- valid  in  1  input sample strobe (downsampled FIFO read side)
- data  in  8  input sample
- blankingregion  in  1  sample flagged as blanking; qualified by valid
- start  in  1  one-cycle arm request
- continuous  in  1  1 = rearm after each frame; 0 = one frame per start
- pix_data  out  8  active sample
- pix_valid  out  1  pix_data qualifier
- x  out  8  column of current pix_data
- y  out  7  row of current pix_data
- sof  out  1  with first pixel of frame
- eol  out  1  with last pixel of line
- eof  out  1  with last pixel of frame
- busy  out  1  state is not IDLE
- line_err  out  1  one-cycle malformed-line pulse
- frame_cnt  out  16  completed frames

Function
REQ-005 Only cycles with valid=1 SHALL be processed; valid=0 cycles SHALL change no state or counter.
REQ-006 States: IDLE, SYNC, HBLANK, LINE.
REQ-007 IDLE: input ignored; start=1 -> SYNC.
REQ-008 SYNC: blanking-run counter increments per valid blanking sample and clears on a valid non-blanking sample; when it reaches VBLANK_MIN -> HBLANK with y=0.
REQ-009 HBLANK: valid blanking sample -> stay; valid non-blanking sample -> LINE, emit pixel x=0.
REQ-010 LINE: each valid non-blanking sample emits a pixel, x incrementing from 0.
REQ-011 The pixel with x=LINE_WIDTH-1 SHALL assert eol; the state SHALL move to HBLANK and y SHALL increment.
REQ-012 When that pixel also has y=FRAME_LINES-1, eof SHALL assert, frame_cnt SHALL increment (wrapping at 65535->0), and the next state SHALL be SYNC if continuous=1, otherwise IDLE.
REQ-013 sof SHALL assert only with the pixel at x=0, y=0.
REQ-014 Short line: a valid blanking sample in LINE SHALL pulse line_err and move to SYNC; no eol is emitted.
REQ-015 Long line: a valid non-blanking sample in HBLANK with y=FRAME_LINES is not possible, because REQ-012 exits the frame; in HBLANK it starts a new line per REQ-009.
REQ-016 A start pulse while the state is not IDLE SHALL be ignored.
REQ-017 continuous SHALL be sampled only at eof.
REQ-018 Outputs SHALL be registered with 1-cycle latency from the valid input sample.
REQ-019 pix_valid, sof, eol, eof and line_err SHALL be single-cycle pulses.
REQ-020 pix_data, x and y SHALL hold their values between pixels.

Reset
REQ-021 Reset SHALL force state IDLE and clear the blanking-run counter.
REQ-022 Reset SHALL clear all outputs to 0, including frame_cnt.
REQ-023 Reset asserted mid-frame SHALL discard the frame with no eof or line_err.

Structure
REQ-024 The state encoding and the LINE_WIDTH/FRAME_LINES/VBLANK_MIN defaults SHALL live in a shared package, down_seq_pkg.
REQ-025 One sub-module, blank_run_detector, SHALL contain the VBLANK_MIN run counter and its "vblank" flag; everything else stays in the top.

Verification
REQ-026 Bench SHALL cover these directed scenarios:
- Nominal: start, continuous=0; 40 blanking, then 120 lines of 160 pixels each separated by 8 blanking -> 19200 pix_valid; sof at (0,0), eol at x=159, eof at (159,119); frame_cnt=1; IDLE.
- Continuous: continuous=1, three frames, each with 40-sample vblank -> frame_cnt=3, busy stays 1, sof count 3.
- Short line: line 5 has 100 pixels then blanking -> line_err one cycle, no eol for line 5, state SYNC, next frame starts at sof (0,0).
- Sync debounce: 31 blanking, 1 non-blanking, 31 blanking -> no pixels emitted; then 1 more blanking -> HBLANK.
- Valid gaps: nominal frame with valid=0 every other cycle -> pixel stream and counters identical to nominal.
- Reset mid-frame: reset at line 60 -> all outputs 0, IDLE; start then full frame -> frame_cnt=1.
